// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues imem requests at the current PC, tracks in-order
// responses and hands {pc, inst, adef} entries to decode through a valid/ready handshake.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    output logic              pc_write,
    input  logic              flush,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst,
    output logic              id_adef,
    input  logic              id_ready
);

    localparam int CNT_W  = PTR_W + 1;
    localparam int DROP_W = 8;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Queue bookkeeping
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  pend_reg, pend_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;

    // Slot storage
    logic [31:0] slot_pc_reg     [DEPTH];
    logic [31:0] slot_inst_reg   [DEPTH];
    logic        slot_adef_reg   [DEPTH];
    logic        slot_filled_reg [DEPTH];

    logic             has_room;
    logic             aligned;
    logic             req_alloc;
    logic             adef_alloc;
    logic             alloc;
    logic             drop_rsp;
    logic             fill_en;
    logic             deq;
    logic             rsp_consumed;
    logic [PTR_W-1:0] fill_ptr;

    logic [DEPTH-1:0] wr_alloc;
    logic [DEPTH-1:0] wr_fill;
    logic [DEPTH-1:0] wr_deq;

    // ------------------------------------------------------------------
    // Issue / fill / dequeue decisions
    // ------------------------------------------------------------------
    always_comb begin
        has_room   = (count_reg < DEPTH_C);
        aligned    = (pc[1:0] == 2'b00);
        imem_req   = !rst && !flush && has_room && aligned;
        imem_addr  = pc;
        req_alloc  = imem_req && imem_gnt;
        // A misaligned entry waits until every earlier fetch has returned so
        // the queue stays in program order.
        adef_alloc = !rst && !flush && has_room && !aligned && (pend_reg == '0);
        alloc      = req_alloc || adef_alloc;
        pc_write   = !rst && (req_alloc || adef_alloc || flush);

        drop_rsp     = imem_rvalid && (drop_cnt_reg != '0);
        fill_en      = imem_rvalid && (drop_cnt_reg == '0) && (pend_reg != '0);
        rsp_consumed = drop_rsp || fill_en;
        // Oldest unfilled slot sits pend_reg positions behind the tail.
        fill_ptr     = tail_reg - pend_reg[PTR_W-1:0];

        id_valid = (count_reg != '0) && slot_filled_reg[head_reg];
        id_pc    = slot_pc_reg[head_reg];
        id_inst  = slot_inst_reg[head_reg];
        id_adef  = slot_adef_reg[head_reg];
        deq      = id_valid && id_ready && !flush;
    end

    // ------------------------------------------------------------------
    // Pointer / counter next state
    // ------------------------------------------------------------------
    always_comb begin
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        pend_next     = pend_reg;
        drop_cnt_next = drop_cnt_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            pend_next  = '0;
            // Everything still owed by memory for the flushed slots becomes stale.
            drop_cnt_next = drop_cnt_reg + DROP_W'(pend_reg) - DROP_W'(rsp_consumed);
        end else begin
            if (alloc)
                tail_next = tail_reg + PTR_W'(1);
            if (deq)
                head_next = head_reg + PTR_W'(1);
            count_next    = count_reg + CNT_W'(alloc) - CNT_W'(deq);
            pend_next     = pend_reg + CNT_W'(req_alloc) - CNT_W'(fill_en);
            drop_cnt_next = drop_cnt_reg - DROP_W'(drop_rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            pend_reg     <= '0;
            drop_cnt_reg <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            pend_reg     <= pend_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot write strobes
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_sel
            assign wr_alloc[gi] = alloc   && (tail_reg == PTR_W'(gi));
            assign wr_fill[gi]  = fill_en && (fill_ptr == PTR_W'(gi));
            assign wr_deq[gi]   = deq     && (head_reg == PTR_W'(gi));
        end
    endgenerate

    // Alloc, fill and dequeue always target distinct slots in the same cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                slot_pc_reg[i]     <= '0;
                slot_inst_reg[i]   <= '0;
                slot_adef_reg[i]   <= 1'b0;
                slot_filled_reg[i] <= 1'b0;
            end else if (flush) begin
                slot_filled_reg[i] <= 1'b0;
            end else if (wr_alloc[i]) begin
                slot_pc_reg[i]     <= pc;
                slot_inst_reg[i]   <= '0;
                slot_adef_reg[i]   <= adef_alloc;
                slot_filled_reg[i] <= adef_alloc;
            end else if (wr_fill[i]) begin
                slot_inst_reg[i]   <= imem_rdata;
                slot_filled_reg[i] <= 1'b1;
            end else if (wr_deq[i]) begin
                slot_filled_reg[i] <= 1'b0;
            end
        end
    end

    // A response with nothing outstanding means the memory broke ordering rules.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && (drop_cnt_reg == '0) && (pend_reg == '0)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a PC-register/memory environment drives the
// DUT, expected decode entries are queued at issue and a monitor pops them on dequeue.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_write;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adef;
    logic        id_ready;

    if_fetch_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_write(pc_write), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_adef(id_adef),
        .id_ready(id_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } exp_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;
    int grants = 0;
    int pcw    = 0;
    logic        gnt_set, ready_set, flush_set;
    logic [31:0] flush_tgt, pc_reg;
    bit          auto_pc = 1'b1;

    logic        s_req, s_pcw, s_valid, s_rvalid;
    logic [31:0] s_addr, s_idpc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of environment: memory returns in order after lat cycles,
    // PC register advances on pc_write and takes the redirect on flush.
    task automatic cycle();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst && rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = rsp_q[0].data;
        end
        imem_gnt = gnt_set;
        id_ready = ready_set;
        flush    = flush_set;
        pc       = pc_reg;
        #1;
        s_req    = imem_req;
        s_pcw    = pc_write;
        s_valid  = id_valid;
        s_addr   = imem_addr;
        s_idpc   = id_pc;
        s_rvalid = imem_rvalid;
        if (!rst && imem_req && imem_gnt) begin
            grants++;
            rsp_q.push_back('{cyc + lat, mem_word(pc_reg)});
            exp_q.push_back('{pc_reg, mem_word(pc_reg), 1'b0});
        end
        if (pc_write) pcw++;
        @(posedge clk);
        if (rst) begin
            rsp_q.delete();
            exp_q.delete();
        end else begin
            if (imem_rvalid) rsp_q.delete(0);
            if (flush) begin
                exp_q.delete();
                pc_reg = flush_tgt;
            end else if (pc_write && auto_pc) begin
                pc_reg = pc_reg + 32'd4;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] start_pc);
        rst = 1'b1;
        flush_set = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        pc_reg = start_pc;
        grants = 0;
        pcw = 0;
    endtask

    task automatic drain(input string name, input int maxc);
        int n = 0;
        gnt_set = 1'b0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < maxc) begin
            cycle();
            n++;
        end
        check(name, 32'(exp_q.size() + rsp_q.size()), 32'd0);
    endtask

    // Monitor: one comparison and one line per decode transaction.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && !flush && id_valid && id_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL deq_unexpected actual pc=%h inst=%h required no entry", id_pc, id_inst);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (id_pc !== e.pc || id_inst !== e.inst || id_adef !== e.adef) begin
                        errors++;
                        $display("FAIL deq_entry actual pc=%h inst=%h adef=%b required pc=%h inst=%h adef=%b",
                                 id_pc, id_inst, id_adef, e.pc, e.inst, e.adef);
                    end else begin
                        $display("deq pc=%h inst=%h adef=%b", id_pc, id_inst, id_adef);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; pc = '0;
        pc_reg = 32'h1c00_0000; flush_tgt = '0;
        gnt_set = 1'b1; ready_set = 1'b1; flush_set = 1'b0;
        @(negedge clk);

        // Reset state (rst still high, gnt offered)
        cycle();
        cycle();
        check("rst_id_valid", id_valid, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_id_pc",    id_pc, 0);
        check("rst_id_inst",  id_inst, 0);
        check("rst_id_adef",  id_adef, 0);
        rst = 1'b0;
        grants = 0; pcw = 0;

        // Streaming: gnt=1, latency 1, ready=1
        lat = 1; gnt_set = 1'b1; ready_set = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            check("t1_addr", s_addr, 32'h1c00_0000 + 32'(4 * i));
            if (i < 2) check("t1_valid_early", s_valid, 0);
            else       check("t1_id_pc", s_idpc, 32'h1c00_0000 + 32'(4 * (i - 2)));
        end
        check("t1_grants", grants, 12);
        check("t1_pcw", pcw, 12);
        drain("t1_drain", 20);

        // Backpressure fills the queue
        do_reset(32'h1c00_0000);
        lat = 1; gnt_set = 1'b1; ready_set = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("t2_grants", grants, 4);
        check("t2_pcw", pcw, 4);
        check("t2_req_full", s_req, 0);
        check("t2_pcw_full", s_pcw, 0);
        ready_set = 1'b1;
        cycle();
        check("t2_req_full_deq", s_req, 0);
        check("t2_valid_full", s_valid, 1);
        cycle();
        check("t2_req_resume", s_req, 1);
        drain("t2_drain", 30);

        // Flush with 3 requests outstanding at latency 5
        do_reset(32'h1c00_0000);
        lat = 5; gnt_set = 1'b1; ready_set = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        flush_set = 1'b1; flush_tgt = 32'h1c00_0100;
        cycle();
        flush_set = 1'b0;
        check("t3_flush_pcw", s_pcw, 1);
        check("t3_flush_req", s_req, 0);
        check("t3_drop_cnt", dut.drop_cnt_reg, 3);
        cycle();
        cycle();
        check("t3_grants", grants, 5);
        drain("t3_drain", 40);

        // Flush in the same cycle as a response
        do_reset(32'h1c00_0000);
        lat = 2; gnt_set = 1'b1; ready_set = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        flush_set = 1'b1; flush_tgt = 32'h1c00_0200;
        cycle();
        flush_set = 1'b0;
        check("t4_rvalid_at_flush", s_rvalid, 1);
        check("t4_drop_cnt", dut.drop_cnt_reg, 1);
        cycle();
        cycle();
        drain("t4_drain", 40);

        // Misaligned PC with an empty queue
        do_reset(32'h1c00_0002);
        auto_pc = 1'b0; gnt_set = 1'b1; ready_set = 1'b1;
        exp_q.push_back('{32'h1c00_0002, 32'h0, 1'b1});
        cycle();
        check("t5_no_req", s_req, 0);
        check("t5_pcw", s_pcw, 1);
        pc_reg = 32'h1c00_0008;
        drain("t5_drain", 10);
        check("t5_pcw_once", pcw, 1);
        auto_pc = 1'b1;

        // Reset with 2 requests outstanding
        do_reset(32'h1c00_0000);
        lat = 5; gnt_set = 1'b1; ready_set = 1'b1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("t6_id_valid", id_valid, 0);
        check("t6_imem_req", imem_req, 0);
        check("t6_count", dut.count_reg, 0);
        cycle();
        rst = 1'b0;
        lat = 1; gnt_set = 1'b1;
        cycle();
        drain("t6_drain", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Issues instruction-memory requests at the current PC and drives the PC register's write enable so the PC advances only when a request is accepted.
- Tracks in-order, variable-latency responses and buffers {pc, inst} pairs in a small queue feeding decode through a valid/ready handshake.
- Handles pipeline flush by dropping buffered entries and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries including in-flight reservations; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pc  in  32  current PC from the PC register.
- pc_write  out  1  PC register write enable.
- flush  in  1  redirect/flush from a later stage; PC register sees it in the same cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, equal to pc.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  head entry valid for decode.
- id_pc  out  32  PC of head entry.
- id_inst  out  32  instruction of head entry; 0 when id_adef=1.
- id_adef  out  1  fetch-address-misaligned exception flag for head entry.
- id_ready  in  1  decode accepts the head entry.

Behaviour:
- Queue is a circular buffer of DEPTH slots with fields {pc, inst, adef, filled}, plus head pointer, tail pointer and count (PTR_W+1 bits).
- A slot is allocated at issue time and filled on response.
- Reset: head=tail=count=0, all filled=0, drop_cnt=0.
  - Outputs: id_valid=0, imem_req=0, pc_write=0, id_pc=0, id_inst=0, id_adef=0.
  - Reset overrides every other input in the same cycle, including mid-transaction; no response is ever expected after reset.
- Issue condition: !rst && !flush && count<DEPTH && pc[1:0]==0.
  - imem_req = issue condition.
  - imem_addr = pc, combinational.
- On imem_req && imem_gnt: allocate the tail slot with pc and filled=0; tail++.
- Misaligned pc (pc[1:0]!=0):
  - No memory request is made.
  - If count<DEPTH, !flush, and no slot is unfilled: allocate a slot with adef=1, inst=0, filled=1. This preserves program order.
- pc_write = (imem_req && imem_gnt) || adef_alloc || flush. The PC advances exactly once per allocated slot, and takes the redirect on flush.
- Response handling:
  - If imem_rvalid && drop_cnt!=0: discard the response; drop_cnt--.
  - Otherwise imem_rvalid fills the oldest unfilled slot (tracked by a fill pointer) with inst=imem_rdata, filled=1.
  - imem_rvalid with no unfilled slot and drop_cnt==0 is a protocol error; ignore it and assert in simulation.
- Decode output:
  - id_valid = count!=0 && slot[head].filled.
  - id_pc, id_inst and id_adef come from slot[head], combinationally.
  - Dequeue on id_valid && id_ready: head++, slot filled cleared.
  - Zero-latency bypass from imem_rvalid to id_valid is not allowed. The earliest id_valid is the cycle after the response.
- Simultaneous events: allocate and dequeue in one cycle leaves count unchanged. A full queue with dequeue this cycle does not issue; issue is based on registered count.
- Flush, taking effect at the next edge:
  - head=tail=fill=count=0; all filled=0.
  - drop_cnt = (unfilled slots) + drop_cnt − (1 if imem_rvalid this cycle).
  - id_valid is ignored by decode in the flush cycle; dequeue is suppressed.
- Pointers wrap modulo DEPTH; count saturates neither up nor down under legal use.

Test Plan:
- Reset with pc=0x1c000000, gnt held 1, 1-cycle response latency, id_ready=1:
  - Required: imem_addr sequence 0x1c000000, 0x1c000004, …
  - Required: id_pc follows the same sequence 2 cycles later, id_inst equal to rdata.
  - Required: one pc_write per grant.
- id_ready=0 with gnt=1:
  - Required: exactly DEPTH=4 grants, then imem_req=0 and pc_write=0.
  - Raise id_ready: entries 0x1c000000..0x1c00000c drain in order and issue resumes.
- 3 requests outstanding (latency 5), then flush with pc→0x1c000100:
  - Required: the 3 stale responses are dropped.
  - Required: the first id_pc after the flush is 0x1c000100 with its own rdata.
- Flush coinciding with imem_rvalid:
  - Required: that response is dropped and drop_cnt equals the remaining unfilled count.
  - Required: no stale instruction reaches decode.
- pc=0x1c000002 with the queue empty:
  - Required: no imem_req.
  - Required: an entry with id_adef=1, id_pc=0x1c000002, id_inst=0, with pc_write=1 once.
- Assert rst while 2 requests are outstanding:
  - Required: next cycle id_valid=0, imem_req=0, count=0.
